sodor3_ib_instr_gen: RTL and testbench

Synthesizable constrained-random instruction source for the sodor3 verification harness. It sits directly upstream of sodor3_verif and drives its instruction input. It emits a stream of I-type ALU-immediate and B-type branch instructions from an LFSR, with a valid/ready handshake, NOP padding and a bounded run length. It replaces software random sampling, so streams are reproducible in simulation and usable under formal/emulation.

---
 rtl/sodor3_igen_pkg.sv | 29 ++
 rtl/sodor3_igen_lfsr.sv | 45 ++++
 rtl/sodor3_ib_instr_gen.sv | 141 ++++++++++++++
 tb/tb_sodor3_ib_instr_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sodor3_igen_pkg.sv
// Shared constants, state encoding and LFSR step for the sodor3 instruction generator.
// The optional mixed I/B stream is enabled by defining BRANCH_GEN_EN.
package sodor3_igen_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  // Shift-immediate forms keep only legal shamt/funct7 bits
  localparam logic [11:0] IMM_MASK_SRAI = 12'h41F;
  localparam logic [11:0] IMM_MASK_SLLI = 12'h01F;

  localparam int TAP_A = 63;
  localparam int TAP_B = 62;
  localparam int TAP_C = 60;
  localparam int TAP_D = 59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/sodor3_igen_lfsr.sv
// 64-bit Fibonacci LFSR with seed load and a multi-step advance per request.
// Exposes its next state so the top can encode the word it is about to register.
module sodor3_igen_lfsr
  import sodor3_igen_pkg::*;
#(
  parameter logic [63:0] SEED  = 64'h0000_0000_0001_7E34,
  parameter int          STEPS = 8
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        load_i,
  input  logic [63:0] seed_i,
  input  logic        adv_i,
  output logic [63:0] next_o
);

  logic [63:0] state_q;
  logic [63:0] state_d;
  logic [63:0] adv_val;

  always_comb begin
    adv_val = state_q;
    for (int i = 0; i < STEPS; i++) begin
      adv_val = lfsr_step(adv_val);
    end
    state_d = state_q;
    // A zero seed would lock the LFSR, so fall back to the build-time seed
    if (load_i) begin
      state_d = (seed_i == 64'd0) ? SEED : seed_i;
    end else if (adv_i) begin
      state_d = adv_val;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign next_o = state_d;

endmodule

// File: rtl/sodor3_ib_instr_gen.sv
// LFSR-driven I-type / B-type instruction source with valid/ready, NOP warmup and bounded runs.
// Define BRANCH_GEN_EN for the mixed I/B stream; otherwise only I-type words are produced.
module sodor3_ib_instr_gen
  import sodor3_igen_pkg::*;
#(
  parameter logic [63:0] SEED      = 64'h0000_0000_0001_7E34,
  parameter int          STEPS     = 8,
  parameter int          WARMUP    = 4,
  parameter logic [31:0] NUM_INSTR = 32'd100
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic        seed_load_i,
  input  logic [63:0] seed_in_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] issued_count_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [31:0] WARMUP_N = 32'(WARMUP);

  state_e      state_q, state_d;
  logic [31:0] warm_q, warm_d;
  logic [31:0] issued_q, issued_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        lfsr_load;
  logic        lfsr_adv;
  logic [63:0] lfsr_d;
  logic        accept;
  logic [11:0] imm;
  logic [2:0]  f3;
  logic [31:0] word;

  sodor3_igen_lfsr #(
    .SEED  (SEED),
    .STEPS (STEPS)
  ) u_lfsr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (lfsr_load),
    .seed_i    (seed_in_i),
    .adv_i     (lfsr_adv),
    .next_o    (lfsr_d)
  );

  assign accept = valid_q & instr_ready_i;

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    issued_d  = issued_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        lfsr_load = seed_load_i;
        if (start_i) begin
          warm_d   = 32'd0;
          issued_d = 32'd0;
          state_d  = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
        end
      end
      ST_WARMUP: begin
        if (accept) begin
          warm_d = warm_q + 32'd1;
          if (warm_q + 32'd1 == WARMUP_N) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          lfsr_adv = 1'b1;
          if (issued_q != 32'hFFFF_FFFF) issued_d = issued_q + 32'd1;
          if ((NUM_INSTR != 32'd0) && (issued_q + 32'd1 == NUM_INSTR)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Encode from the LFSR's next state so the registered word lines up with it
`ifdef BRANCH_GEN_EN
  logic [2:0] fb;
  logic       unused_bits;
  assign unused_bits = ^lfsr_d[63:34];
`else
  logic       unused_bits;
  assign unused_bits = ^{lfsr_d[63:30], lfsr_d[21:17]};
`endif

  always_comb begin
    imm = lfsr_d[11:0];
    f3  = lfsr_d[29:27];
    if (f3 == 3'd5) begin
      imm = imm & IMM_MASK_SRAI;
    end else if (f3 == 3'd1) begin
      imm = imm & IMM_MASK_SLLI;
    end
    word = {imm, lfsr_d[16:12], f3, lfsr_d[26:22], OPC_OPIMM};
`ifdef BRANCH_GEN_EN
    fb = lfsr_d[32:30];
    if (!fb[2]) fb = fb & 3'b001;
    if (!lfsr_d[33]) begin
      word = {imm[11], imm[9:4], lfsr_d[21:17], lfsr_d[16:12], fb,
              imm[3:1], 1'b0, imm[10], OPC_BRANCH};
    end
`endif
  end

  always_comb begin
    instr_d = (state_d == ST_RUN) ? word : NOP;
    valid_d = (state_d == ST_WARMUP) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      warm_q   <= 32'd0;
      issued_q <= 32'd0;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      issued_q <= issued_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign instr_valid_o  = valid_q;
  assign instr_o        = instr_q;
  assign issued_count_o = issued_q;
  assign busy_o         = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_sodor3_ib_instr_gen.sv
// Scoreboard bench for sodor3_ib_instr_gen: expected words are queued at start, popped on accept.
module tb_sodor3_ib_instr_gen;

  localparam logic [63:0] SEED   = 64'h0000_0000_0001_7E34;
  localparam int          STEPS  = 8;
  localparam int          WARMUP = 4;
  localparam int          NUM    = 10;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [63:0] seed_in = 64'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] issued_count;
  logic        busy;
  logic        done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [63:0] m;
  logic [31:0] first_rand;

  sodor3_ib_instr_gen #(
    .SEED      (SEED),
    .STEPS     (STEPS),
    .WARMUP    (WARMUP),
    .NUM_INSTR (32'(NUM))
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .start_i        (start),
    .seed_load_i    (seed_load),
    .seed_in_i      (seed_in),
    .instr_valid_o  (instr_valid),
    .instr_ready_i  (instr_ready),
    .instr_o        (instr),
    .issued_count_o (issued_count),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] adv(input logic [63:0] s);
    logic [63:0] r = s;
    for (int k = 0; k < STEPS; k++) begin
      r = {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
    end
    return r;
  endfunction

  function automatic logic [31:0] enc(input logic [63:0] s);
    logic [11:0] im = s[11:0];
    logic [2:0]  fn = s[29:27];
    logic [2:0]  fb = s[32:30];
    logic        ib = s[33];
    if (fn == 3'd5) im = im & 12'h41F;
    if (fn == 3'd1) im = im & 12'h01F;
    if (fb[2] == 1'b0) fb = {2'b00, fb[0]};
`ifndef BRANCH_GEN_EN
    ib = 1'b1;
`endif
    if (ib) return {im, s[16:12], fn, s[26:22], 7'b0010011};
    return {im[11], im[9:4], s[21:17], s[16:12], fb, im[3:1], 1'b0, im[10], 7'b1100011};
  endfunction

  // Entered and left on a falling edge
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_instr", instr, NOP_W);
    chk("rst_valid", instr_valid, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    m = SEED;
  endtask

  task automatic run(input bit do_load, input logic [63:0] sd, input bit rnd, input int abort_after);
    int  nacc = 0;
    int  nrand = 0;
    int  stall_left = 0;
    int  cyc = 0;
    bit  stalled = 1'b0;
    logic [31:0] w;
    if (do_load) m = (sd == 64'd0) ? SEED : sd;
    for (int i = 0; i < WARMUP; i++) exp_q.push_back(NOP_W);
    for (int i = 0; i < NUM; i++) begin
      exp_q.push_back(enc(m));
      m = adv(m);
    end
    start = 1'b1;
    seed_load = do_load;
    seed_in = sd;
    instr_ready = 1'b0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      seed_load = 1'b0;
      cyc++;
      if (cyc > 400) begin
        chk("timeout", 64'(exp_q.size()), 0);
        break;
      end
      if (abort_after > 0 && nrand == abort_after) break;
      if (exp_q.size() == 0) break;
      chk("valid", instr_valid, 1);
      chk("instr", instr, exp_q[0]);
      chk("issued", issued_count, 64'(nrand));
      chk("busy", busy, 1);
      if (!rnd && nrand == 3 && !stalled) begin
        stalled = 1'b1;
        stall_left = 5;
        start = 1'b1;
      end
      if (stall_left > 0) begin
        instr_ready = 1'b0;
        stall_left--;
      end else begin
        instr_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (instr_ready) begin
        w = exp_q.pop_front();
        if (nacc >= WARMUP) begin
          if (nrand == 0) first_rand = w;
          nrand++;
        end
        nacc++;
        $display("accept %0d word %h", nacc, w);
      end
    end
    if (abort_after == 0) begin
      chk("done", done, 1);
      chk("done_valid", instr_valid, 0);
      chk("done_instr", instr, NOP_W);
      chk("done_issued", issued_count, 64'(NUM));
      chk("done_busy", busy, 0);
    end
  endtask

  initial begin
    m = SEED;
    first_rand = 32'd0;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);
    chk("idle_instr", instr, NOP_W);
    chk("idle_valid", instr_valid, 0);
    chk("idle_done", done, 0);

    run(1'b0, 64'd0, 1'b0, 0);
`ifdef BRANCH_GEN_EN
    chk("seed_word", first_rand, 32'hC60B_84E3);
`else
    chk("seed_word", first_rand, 32'hE34B_8013);
`endif

    run(1'b0, 64'd0, 1'b1, 0);

    run(1'b1, 64'h0000_0002_2800_0FFF, 1'b1, 0);
    chk("imm_srai", 64'(first_rand[31:20]), 64'h41F);
    run(1'b1, 64'h0000_0002_0800_0FFF, 1'b0, 0);
    chk("imm_slli", 64'(first_rand[31:20]), 64'h01F);
    run(1'b1, 64'h0000_0000_8000_0FFF, 1'b1, 0);
    chk("fb_mask", 64'(first_rand[14:12]), 64'h0);
`ifdef BRANCH_GEN_EN
    chk("br_opc", 64'(first_rand[6:0]), 64'h63);
`else
    chk("ionly_opc", 64'(first_rand[6:0]), 64'h13);
`endif

    run(1'b1, 64'd0, 1'b0, 0);
    chk("seed0_word", first_rand, enc(SEED));

    run(1'b0, 64'd0, 1'b0, 7);
    do_reset();
    run(1'b0, 64'd0, 1'b0, 0);
    chk("rerun_word", first_rand, enc(SEED));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
